// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, default parameters and ACK levels for the I2C slave engine.
package i2c_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_DATA  = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } state_t;
    localparam logic [6:0] DEF_SLAVE_ADDR = 7'h41;
    localparam int DEF_FILTER_LEN = 3;
    localparam int DEF_SDA_HOLD = 4;
    localparam logic ACK = 1'b0;
    localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_slave_engine_if.sv
// i2c_slave_engine_if: pad lines plus register-file handshake of the I2C slave engine.
interface i2c_slave_engine_if;
    logic scl_in, sda_in, scl_oe, sda_oe;
    logic start, stop, data_vld, r_w, busy, stretch_on;
    logic [7:0] i2c_to_data, data_to_i2c;
    modport slave (
        input  scl_in, sda_in, data_to_i2c, stretch_on,
        output scl_oe, sda_oe, start, stop, data_vld, r_w, i2c_to_data, busy
    );
    modport master (
        output scl_in, sda_in, data_to_i2c, stretch_on,
        input  scl_oe, sda_oe, start, stop, data_vld, r_w, i2c_to_data, busy
    );
endinterface

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-flop synchroniser, LEN-sample stability filter and edge flags for one bus line.
module i2c_line_filter #(
    parameter int LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [1:0] sync;
    logic [LEN-1:0] hist;
    // Idle bus is high, so everything resets to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '1;
            hist  <= '1;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            hist  <= {hist[LEN-2:0], sync[1]};
            level <= &hist ? 1'b1 : ~|hist ? 1'b0 : level;
            rise  <= &hist & ~level;
            fall  <= ~|hist & level;
        end
    end
endmodule

// File: rtl/i2c_slave_engine.sv
// i2c_slave_engine: bit/byte-level I2C slave with address match, ACK generation,
// read/write shifting and clock stretching toward a register file.
module i2c_slave_engine
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter int FILTER_LEN = DEF_FILTER_LEN,
    parameter int SDA_HOLD = DEF_SDA_HOLD
) (
    input logic clk,
    input logic rst,
    i2c_slave_engine_if.slave bus
);
    localparam int HW = $clog2(SDA_HOLD + 1);
    logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
    logic start_det, stop_det, abort, last, tick, in_ack, ninth, vld_rd;
    logic [7:0] byte_in, tx;
    logic [6:0] rx;
    logic [2:0] bit_cnt;
    logic [HW-1:0] hold_cnt;
    state_t state, state_nxt;

    i2c_line_filter #(.LEN(FILTER_LEN)) u_scl (
        .clk(clk), .rst(rst), .raw(bus.scl_in), .level(scl), .rise(scl_rise), .fall(scl_fall)
    );
    i2c_line_filter #(.LEN(FILTER_LEN)) u_sda (
        .clk(clk), .rst(rst), .raw(bus.sda_in), .level(sda), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;
    assign abort     = start_det | stop_det;
    assign byte_in   = {rx, sda};
    assign last      = bit_cnt == 3'd7;
    assign tick      = hold_cnt == HW'(1);
    assign in_ack    = state inside {ADDR_ACK, WR_ACK, RD_ACK};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ninth marks that the ACK slot's SCL rise has happened, so the next fall ends the slot.
    always_comb begin
        state_nxt = state;
        if (start_det) state_nxt = ADDR;
        else if (stop_det) state_nxt = IDLE;
        else if (scl_rise) begin
            case (state)
                ADDR:    if (last) state_nxt = byte_in[7:1] == SLAVE_ADDR ? ADDR_ACK : IGNORE;
                WR_DATA: if (last) state_nxt = WR_ACK;
                RD_DATA: if (last) state_nxt = RD_ACK;
                RD_ACK:  if (sda == NACK) state_nxt = IGNORE;
                default: ;
            endcase
        end else if (scl_fall && ninth && in_ack)
            state_nxt = (state == WR_ACK || (state == ADDR_ACK && !bus.r_w)) ? WR_DATA : RD_DATA;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt         <= '0;
            rx              <= '0;
            tx              <= '0;
            ninth           <= 1'b0;
            vld_rd          <= 1'b0;
            hold_cnt        <= '0;
            bus.sda_oe      <= 1'b0;
            bus.scl_oe      <= 1'b0;
            bus.start       <= 1'b0;
            bus.stop        <= 1'b0;
            bus.data_vld    <= 1'b0;
            bus.r_w         <= 1'b0;
            bus.i2c_to_data <= '0;
            bus.busy        <= 1'b0;
        end else begin
            bus.start    <= start_det;
            bus.stop     <= stop_det;
            bus.busy     <= start_det | (bus.busy & ~stop_det);
            vld_rd       <= scl_rise && state == RD_ACK && !abort;
            bus.data_vld <= vld_rd | (scl_rise && state == WR_DATA && last && !abort);
            bus.scl_oe   <= bus.stretch_on & ~scl & ~abort & !(state inside {IDLE, IGNORE});
            hold_cnt     <= abort ? '0 : scl_fall ? HW'(SDA_HOLD) : hold_cnt != '0 ? hold_cnt - HW'(1) : '0;
            if (abort) begin
                bit_cnt    <= '0;
                ninth      <= 1'b0;
                bus.sda_oe <= 1'b0;
            end else begin
                if (scl_rise) begin
                    rx      <= byte_in[6:0];
                    bit_cnt <= state inside {ADDR, WR_DATA, RD_DATA} ? bit_cnt + 3'd1 : bit_cnt;
                    ninth   <= in_ack;
                    if (state == ADDR && last && byte_in[7:1] == SLAVE_ADDR) bus.r_w <= sda;
                    if (state == WR_DATA && last) bus.i2c_to_data <= byte_in;
                end
                if (scl_fall) begin
                    ninth <= 1'b0;
                    tx    <= (ninth && in_ack && state_nxt == RD_DATA) ? bus.data_to_i2c :
                             state == RD_DATA ? {tx[6:0], 1'b0} : tx;
                end
                if (tick)
                    bus.sda_oe <= (state == ADDR_ACK || state == WR_ACK) ? ~ACK :
                                  state == RD_DATA ? ~tx[7] : 1'b0;
            end
        end
    end
endmodule

// File: doc/i2c_slave_engine.md
Name: i2c_slave_engine

Overview:
- Bit/byte-level I2C slave front end that sits directly upstream of the register file.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches the 7-bit slave address, shifts data bytes in and out, and drives ACK and clock stretch.
- Presents start/stop/data_vld/r_w/i2c_to_data to the register file and consumes its data_to_i2c and stretch_on.

Parameters:
- SLAVE_ADDR, 7'h41, 7-bit device address acknowledged.
- FILTER_LEN, 3, consecutive identical samples needed to accept a new SCL/SDA level (glitch filter).
- SDA_HOLD, 4, clk cycles after a filtered SCL fall before sda_oe may change.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- scl_in  in  1  raw SCL pad input.
- sda_in  in  1  raw SDA pad input.
- scl_oe  out  1  1 = pull SCL low (stretch).
- sda_oe  out  1  1 = pull SDA low (ACK / data 0).
- start  out  1  1-clk pulse on START or repeated START.
- stop  out  1  1-clk pulse on STOP.
- data_vld  out  1  1-clk pulse per completed data byte.
- r_w  out  1  R/W bit of the current address byte.
- i2c_to_data  out  8  last received write byte.
- data_to_i2c  in  8  byte to transmit on reads.
- stretch_on  in  1  request to hold SCL low.
- busy  out  1  high from START to STOP.

Behaviour:
- Input conditioning: 2-flop synchroniser, then a FILTER_LEN majority/stable filter per line. Edge flags come from the filtered levels.
- START: filtered SDA falls while filtered SCL is high. STOP: filtered SDA rises while filtered SCL is high.
  - Both are valid in any state and take priority over bit processing in the same clk.
  - START → ADDR with bit_cnt=0. STOP → IDLE.
  - start/stop pulse for every bus event, regardless of address match.
- Bit sampling: SDA is sampled on the filtered SCL rise, MSB first. bit_cnt counts 0..7 and wraps to 0 after each ACK slot.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
  - IDLE: wait for START.
  - ADDR → after 8 bits:
    - If addr[7:1]==SLAVE_ADDR: latch r_w=bit0 and go to ADDR_ACK.
    - Otherwise go to IGNORE (no sda_oe, no data_vld).
  - ADDR_ACK: sda_oe=1 for the ninth SCL period, from SCL fall + SDA_HOLD to the next SCL fall + SDA_HOLD.
    - When r_w=1, data_to_i2c is loaded into the tx shifter at the SCL fall that ends the ACK slot. Next state is RD_DATA.
    - When r_w=0, next state is WR_DATA.
  - WR_DATA: after the 8th sampled bit, update i2c_to_data and pulse data_vld in the same clk (i2c_to_data is stable from that clk until the next byte completes). Then go to WR_ACK.
  - WR_ACK: ACK driven as in ADDR_ACK. No NACK is ever generated on writes. Next state is WR_DATA.
  - RD_DATA: sda_oe = ~tx[7] after each SCL fall + SDA_HOLD; shift on each SCL fall. After the 8th bit, release SDA and go to RD_ACK.
  - RD_ACK: sample the master ACK on SCL rise and pulse data_vld one clk later.
    - ACK(0): go to RD_DATA; reload data_to_i2c at the SCL fall ending the slot. The register file needs ≥3 clk between data_vld and that fall, which holds for SCL ≤1 MHz at clk ≥25 MHz.
    - NACK(1): go to IGNORE with SDA released.
  - IGNORE: outputs idle; wait for START/STOP.
- r_w holds until the next address byte is received; it resets to 0.
- Stretch: when stretch_on=1 and filtered SCL is low in a non-IDLE/IGNORE state, scl_oe=1. It is released the first clk after stretch_on drops. Stretch never starts while SCL is high.
- STOP or START mid-byte: discard the partial byte, no data_vld, release sda_oe and scl_oe in the same clk.
- Reset values: every output is 0, FSM=IDLE, shifters=0. Reset mid-transfer releases both lines immediately (asynchronous).
- busy: set on START, cleared on STOP.

Decomposition:
- Shared package i2c_pkg holds:
  - the FSM state encoding (localparam 3-bit codes);
  - default SLAVE_ADDR, FILTER_LEN and SDA_HOLD constants;
  - ACK/NACK level constants.
- One natural sub-module, i2c_line_filter: synchroniser plus stability filter plus rise/fall flags. It is instantiated twice, once for SCL and once for SDA.

Test Plan:
- Write 0x41|W, bytes 0x10, 0xF8, 0x2A, STOP:
  - ACK on all 4 bytes;
  - data_vld ×3 with i2c_to_data = 0x10, 0xF8, 0x2A;
  - r_w=0; start ×1, stop ×1.
- Write 0x41|W, 0x24, repeated START, 0x41|R, master ACK then NACK, with data_to_i2c set to 0x5A and then 0xC3:
  - SDA carries 0x5A then 0xC3;
  - data_vld ×2 on the read side; start ×2;
  - SDA released after the NACK.
- Address 0x42|W followed by 2 bytes → no ACK, sda_oe never 1, no data_vld, start/stop still pulse.
- STOP injected after 4 bits of a write data byte → no data_vld, FSM=IDLE, sda_oe=0 within 1 clk of the stop pulse.
- stretch_on=1 for 200 clk during WR_ACK low phase → scl_oe=1 for the full 200 clk; released 1 clk after stretch_on falls; transfer completes correctly.
- 1-clk glitches on SCL and SDA (shorter than FILTER_LEN) during a transfer → no spurious START/STOP/bit. rst=0 asserted mid-read → all outputs 0 immediately, next transaction succeeds.
